// File: rtl/piso_arb_ctrl.sv
// Round-robin two-requester arbiter that feeds a parallel-in/serial-out shifter.
// Frames go out MSB first with valid/last/source markers and an optional idle gap.
module piso_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             ser_src,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] BIT_INIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bitcnt;
    logic [GW-1:0]    gapcnt;
    logic             last_grant;
    logic             grant_vld;
    logic             grant_id;

    always_comb begin
        grant_vld  = 1'b0;
        grant_id   = 1'b0;
        state_nx   = state;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        ser_last   = 1'b0;

        // Grants only happen in IDLE; a tie goes to whoever was not served last.
        if (state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (grant_vld) state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = sreg[WIDTH-1];
                ser_last  = (bitcnt == '0);
                if (bitcnt == '0) state_nx = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gapcnt == '0) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign req0_ready = grant_vld & ~grant_id;
    assign req1_ready = grant_vld & grant_id;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg       <= '0;
            bitcnt     <= '0;
            gapcnt     <= '0;
            last_grant <= 1'b1;
            ser_src    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        sreg       <= grant_id ? req1_data : req0_data;
                        bitcnt     <= BIT_INIT;
                        last_grant <= grant_id;
                        ser_src    <= grant_id;
                    end
                end
                ST_SHIFT: begin
                    sreg   <= {sreg[WIDTH-2:0], 1'b0};
                    bitcnt <= bitcnt - 1'b1;
                    if (bitcnt == '0) gapcnt <= GAP_INIT;
                end
                ST_GAP: begin
                    if (gapcnt != '0) gapcnt <= gapcnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Directed bench for piso_arb_ctrl: one GAP=1 instance and one GAP=0 instance,
// expected values hand-computed from the frame timing.
module tb_piso_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       r0v = 1'b0, r1v = 1'b0;
    logic [3:0] r0d = '0, r1d = '0;
    logic       r0r, r1r, so, sv, sl, ss, bsy;

    logic       g_r0v = 1'b0, g_r1v = 1'b0;
    logic [3:0] g_r0d = '0, g_r1d = '0;
    logic       g_r0r, g_r1r, g_so, g_sv, g_sl, g_ss, g_bsy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    piso_arb_ctrl #(.WIDTH(4), .GAP(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
        .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
        .ser_out(so), .ser_valid(sv), .ser_last(sl), .ser_src(ss), .busy(bsy)
    );

    piso_arb_ctrl #(.WIDTH(4), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst(rst),
        .req0_valid(g_r0v), .req0_data(g_r0d), .req0_ready(g_r0r),
        .req1_valid(g_r1v), .req1_data(g_r1d), .req1_ready(g_r1r),
        .ser_out(g_so), .ser_valid(g_sv), .ser_last(g_sl), .ser_src(g_ss), .busy(g_bsy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r0v = 1'b0; r1v = 1'b0; g_r0v = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Entered at the first-bit sample point; leaves at the last-bit sample point.
    task automatic get_frame(output logic [3:0] w, output int nvalid, output int nlast);
        w = '0; nvalid = 0; nlast = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            w = {w[2:0], so};
            if (sv) nvalid++;
            if (sl) nlast++;
        end
    endtask

    initial begin
        logic [3:0]  w;
        logic [3:0]  frm [3];
        logic        src [3];
        logic [3:0]  cur;
        logic [13:0] bvec, vvec;
        int nv, nl, nf, idle, ngaps, gaperr, ovl, cnt;

        do_reset();
        check("rst_ser_valid", sv, 0);
        check("rst_busy", bsy, 0);
        check("rst_readys", {r0r, r1r, so, sl, ss}, 0);

        // single req0 frame 1011
        r0v = 1'b1; r0d = 4'b1011;
        #1;
        check("t1_ready", {r0r, r1r}, 2'b10);
        tick();
        r0v = 1'b0;
        check("t1_ready_drop", r0r, 0);
        check("t1_first_bit", {sv, so, sl, ss}, 4'b1100);
        get_frame(w, nv, nl);
        check("t1_word", w, 4'b1011);
        check("t1_nvalid", nv, 4);
        check("t1_last_bit", {sl, nl[3:0]}, 5'b1_0001);
        tick();
        check("t1_gap", {sv, bsy, so, sl}, 4'b0100);
        tick();
        check("t1_idle", {sv, bsy}, 2'b00);

        // both requesters held: A(0), 5(1), A(0), two idle cycles between frames
        do_reset();
        r0v = 1'b1; r0d = 4'hA; r1v = 1'b1; r1d = 4'h5;
        #1;
        check("t2_first_grant", {r0r, r1r}, 2'b10);
        nf = 0; idle = 0; ngaps = 0; gaperr = 0; ovl = 0; cur = '0;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (r0r && r1r) ovl++;
            if (sv) begin
                if (nf > 0 && idle != 0) begin
                    ngaps++;
                    if (idle != 2) gaperr++;
                end
                idle = 0;
                cur = {cur[2:0], so};
                if (sl) begin
                    if (nf < 3) begin
                        frm[nf] = cur;
                        src[nf] = ss;
                    end
                    nf++;
                end
            end else begin
                idle++;
            end
        end
        check("t2_nframes", nf, 3);
        check("t2_frames", {frm[0], frm[1], frm[2]}, 12'hA5A);
        check("t2_srcs", {src[0], src[1], src[2]}, 3'b010);
        check("t2_ngaps", ngaps, 2);
        check("t2_gap_len", gaperr, 0);
        check("t2_ready_overlap", ovl, 0);

        // req1 arrives mid-frame, waits for IDLE, then its word goes out unchanged
        do_reset();
        r0v = 1'b1; r0d = 4'h6;
        #1;
        tick();
        r0v = 1'b0; r1v = 1'b1; r1d = 4'h9;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (r1r) cnt++;
            if (c == 3) check("t3_src0_frame_last", {sl, ss}, 2'b10);
            tick();
        end
        check("t3_ready1_blocked", cnt, 0);
        check("t3_ready1_idle", {bsy, r0r, r1r}, 3'b001);
        tick();
        r1v = 1'b0;
        get_frame(w, nv, nl);
        check("t3_word", w, 4'h9);
        check("t3_src", ss, 1);

        // GAP=0 with req0 continuously valid: exactly one idle cycle between frames
        do_reset();
        g_r0v = 1'b1; g_r0d = 4'h3;
        #1;
        tick();
        bvec = '0; vvec = '0;
        for (int c = 0; c < 14; c++) begin
            bvec[c] = g_bsy;
            vvec[c] = g_sv;
            if (c == 4) check("t4_idle_ready", {g_r0r, g_so, g_sl}, 3'b100);
            tick();
        end
        g_r0v = 1'b0;
        check("t4_busy_pattern", bvec, 14'b11110111101111);
        check("t4_valid_pattern", vvec, 14'b11110111101111);

        // async reset mid-frame after 2nd bit of 1100; re-arbitration favours req0
        do_reset();
        r0v = 1'b1; r0d = 4'b1100;
        #1;
        tick();
        r0v = 1'b0;
        tick();
        check("t5_pre_rst", {sv, so, bsy}, 3'b111);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_rst", {sv, so, bsy, sl}, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r0v = 1'b1; r0d = 4'h8; r1v = 1'b1; r1d = 4'h7;
        #1;
        check("t5_post_rst_grant", {r0r, r1r}, 2'b10);
        tick();
        r0v = 1'b0; r1v = 1'b0;
        check("t5_post_rst_frame", {sv, so, ss}, 3'b110);

        // idle with nothing valid after a req1 frame: outputs quiet, ser_src held
        do_reset();
        r1v = 1'b1; r1d = 4'h2;
        #1;
        tick();
        r1v = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (sv || bsy || r0r || r1r) cnt++;
            tick();
        end
        check("t6_idle_quiet", cnt, 0);
        check("t6_src_held", ss, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
